// File: rtl/branch_predictor_2lvl.sv
// Two-level local branch predictor: per-branch history table indexing saturating counters; init walker clears tables after reset.
// Latency: 1 cycle from accepted request to registered response; optional same-cycle update forwarding under BP_BYPASS_EN.
// Backpressure: req_ready low while initialising; responses and updates are never stalled.
module branch_predictor_2lvl #(
    parameter int BHT_ENTRIES = 16,
    parameter int HIST_BITS   = 4,
    parameter int PC_PHT_BITS = 3,
    parameter int CTR_BITS    = 2,
    localparam int BHT_IDX    = $clog2(BHT_ENTRIES),
    localparam int PHT_IDX    = PC_PHT_BITS + HIST_BITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [31:0]        req_pc,
    output logic               resp_valid,
    output logic               resp_taken,
    output logic [BHT_IDX-1:0] resp_bht_index,
    output logic [PHT_IDX-1:0] resp_pht_index,
    input  logic               upd_en,
    input  logic [BHT_IDX-1:0] upd_bht_index,
    input  logic [PHT_IDX-1:0] upd_pht_index,
    input  logic               upd_taken
);

    localparam int PHT_ENTRIES = 1 << PHT_IDX;
    localparam int INIT_N      = (PHT_ENTRIES > BHT_ENTRIES) ? PHT_ENTRIES : BHT_ENTRIES;
    localparam int INIT_W      = (PHT_IDX > BHT_IDX) ? PHT_IDX : BHT_IDX;
    localparam int NCHUNK      = (30 + BHT_IDX - 1) / BHT_IDX;
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [INIT_W-1:0]         r_init_ptr;
    logic                      w_init_last;

    logic [HIST_BITS-1:0]      r_bht [BHT_ENTRIES];
    logic [CTR_BITS-1:0]       r_pht [PHT_ENTRIES];

    logic                      r_resp_valid;
    logic                      r_resp_taken;
    logic [BHT_IDX-1:0]        r_resp_bht_index;
    logic [PHT_IDX-1:0]        r_resp_pht_index;

    logic [NCHUNK*BHT_IDX-1:0] w_pc_ext;
    logic [BHT_IDX-1:0]        w_lk_bht_idx;
    logic [HIST_BITS-1:0]      w_lk_hist;
    logic [PHT_IDX-1:0]        w_lk_pht_idx;
    logic [CTR_BITS-1:0]       w_lk_ctr;
    logic                      w_acc;
    logic                      w_upd_act;
    logic [HIST_BITS-1:0]      w_upd_hist_nxt;
    logic [CTR_BITS-1:0]       w_upd_ctr_old;
    logic [CTR_BITS-1:0]       w_upd_ctr_nxt;
    logic                      w_unused_pc_lsb;

    assign w_unused_pc_lsb = &{1'b0, req_pc[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_INIT;
            r_init_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_INIT) begin
                r_init_ptr <= r_init_ptr + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_last = 1'b0;
        req_ready   = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_last = (r_init_ptr == INIT_W'(INIT_N - 1));
                if (w_init_last) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                req_ready = 1'b1;
            end
            default: w_state_nxt = S_INIT;
        endcase
    end

    assign w_acc     = req_valid && req_ready;
    assign w_upd_act = upd_en && (r_state == S_RUN);

    // BHT index: XOR-fold of word-aligned PC in BHT_IDX-bit chunks, top chunk zero-padded.
    assign w_pc_ext = (NCHUNK*BHT_IDX)'(req_pc[31:2]);
    always_comb begin
        w_lk_bht_idx = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            w_lk_bht_idx = w_lk_bht_idx ^ w_pc_ext[c*BHT_IDX +: BHT_IDX];
        end
    end

    generate
        if (HIST_BITS == 1) begin : g_hist1
            assign w_upd_hist_nxt = upd_taken;
        end else begin : g_histn
            assign w_upd_hist_nxt = {r_bht[upd_bht_index][HIST_BITS-2:0], upd_taken};
        end
    endgenerate

    assign w_upd_ctr_old = r_pht[upd_pht_index];
    always_comb begin
        w_upd_ctr_nxt = w_upd_ctr_old;
        if (upd_taken) begin
            if (w_upd_ctr_old != CTR_MAX) w_upd_ctr_nxt = w_upd_ctr_old + CTR_BITS'(1);
        end else begin
            if (w_upd_ctr_old != '0) w_upd_ctr_nxt = w_upd_ctr_old - CTR_BITS'(1);
        end
    end

`ifdef BP_BYPASS_EN
    // Forward this cycle's update so the lookup sees post-update history and counter.
    assign w_lk_hist = (w_upd_act && (upd_bht_index == w_lk_bht_idx)) ? w_upd_hist_nxt
                                                                      : r_bht[w_lk_bht_idx];
`else
    assign w_lk_hist = r_bht[w_lk_bht_idx];
`endif

    generate
        if (PC_PHT_BITS > 0) begin : g_pcbits
            assign w_lk_pht_idx = {req_pc[PC_PHT_BITS+1:2], w_lk_hist};
        end else begin : g_nopcbits
            assign w_lk_pht_idx = w_lk_hist;
        end
    endgenerate

`ifdef BP_BYPASS_EN
    assign w_lk_ctr = (w_upd_act && (upd_pht_index == w_lk_pht_idx)) ? w_upd_ctr_nxt
                                                                     : r_pht[w_lk_pht_idx];
`else
    assign w_lk_ctr = r_pht[w_lk_pht_idx];
`endif

    // Tables carry no reset; the walker rewrites every entry while in INIT.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == S_INIT) begin
                r_bht[r_init_ptr[BHT_IDX-1:0]] <= '0;
                r_pht[r_init_ptr[PHT_IDX-1:0]] <= CTR_WEAK;
            end else if (w_upd_act) begin
                r_bht[upd_bht_index] <= w_upd_hist_nxt;
                r_pht[upd_pht_index] <= w_upd_ctr_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_valid     <= 1'b0;
            r_resp_taken     <= 1'b0;
            r_resp_bht_index <= '0;
            r_resp_pht_index <= '0;
        end else begin
            r_resp_valid <= w_acc;
            if (w_acc) begin
                r_resp_taken     <= w_lk_ctr[CTR_BITS-1];
                r_resp_bht_index <= w_lk_bht_idx;
                r_resp_pht_index <= w_lk_pht_idx;
            end
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_taken     = r_resp_taken;
    assign resp_bht_index = r_resp_bht_index;
    assign resp_pht_index = r_resp_pht_index;

endmodule

// File: tb/tb_branch_predictor_2lvl.sv
// Directed plus randomized bench for branch_predictor_2lvl against an array-based reference model.
module tb_branch_predictor_2lvl;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_taken;
    logic [3:0]  resp_bht_index;
    logic [6:0]  resp_pht_index;
    logic        upd_en;
    logic [3:0]  upd_bht_index;
    logic [6:0]  upd_pht_index;
    logic        upd_taken;

    branch_predictor_2lvl dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .resp_valid     (resp_valid),
        .resp_taken     (resp_taken),
        .resp_bht_index (resp_bht_index),
        .resp_pht_index (resp_pht_index),
        .upd_en         (upd_en),
        .upd_bht_index  (upd_bht_index),
        .upd_pht_index  (upd_pht_index),
        .upd_taken      (upd_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_err;
    int bht_m [16];
    int pht_m [128];
    int exp_bht;
    int exp_pht;
    int exp_taken;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int hash_pc(input logic [31:0] pc);
        int unsigned x;
        int h;
        x = pc >> 2;
        h = 0;
        while (x != 0) begin
            h = h ^ int'(x % 16);
            x = x / 16;
        end
        return h;
    endfunction

    function automatic int sat_next(input int c, input bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_init();
        for (int i = 0; i < 16; i++) bht_m[i] = 0;
        for (int i = 0; i < 128; i++) pht_m[i] = 2;
        exp_bht = 0;
        exp_pht = 0;
        exp_taken = 0;
    endtask

    // One RUN-state cycle: drive, predict from the model, clock, update model, check.
    task automatic step(input bit rv, input logic [31:0] pc, input bit ue,
                        input int ub, input int up, input bit ut);
        int eb;
        int ep;
        int hist;
        int ctr;
        req_valid     = rv;
        req_pc        = pc;
        upd_en        = ue;
        upd_bht_index = 4'(ub);
        upd_pht_index = 7'(up);
        upd_taken     = ut;
        eb   = hash_pc(pc);
        hist = bht_m[eb];
`ifdef BP_BYPASS_EN
        if (ue && ub == eb) hist = (hist * 2 + int'(ut)) % 16;
`endif
        ep  = int'((pc >> 2) & 32'h7) * 16 + hist;
        ctr = pht_m[ep];
`ifdef BP_BYPASS_EN
        if (ue && up == ep) ctr = sat_next(ctr, ut);
`endif
        @(posedge clk);
        if (ue) begin
            bht_m[ub] = (bht_m[ub] * 2 + int'(ut)) % 16;
            pht_m[up] = sat_next(pht_m[up], ut);
        end
        if (rv) begin
            exp_bht   = eb;
            exp_pht   = ep;
            exp_taken = (ctr >= 2) ? 1 : 0;
        end
        #1;
        chk("resp_valid", resp_valid, rv);
        chk("resp_taken", resp_taken, exp_taken);
        chk("resp_bht_index", resp_bht_index, exp_bht);
        chk("resp_pht_index", resp_pht_index, exp_pht);
    endtask

    initial begin
        int zeros;
        bit rv;
        bit ue;
        bit ut;
        int ub;
        int up;
        logic [31:0] pc;
        n_checks = 0;
        n_err    = 0;
        reset     = 1'b1;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        upd_en    = 1'b0;
        upd_bht_index = '0;
        upd_pht_index = '0;
        upd_taken = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_taken", resp_taken, 0);
        chk("rst_resp_bht", resp_bht_index, 0);
        chk("rst_resp_pht", resp_pht_index, 0);
        reset = 1'b0;
        model_init();

        zeros = 0;
        for (int k = 1; k <= 127; k++) begin
            @(posedge clk); #1;
            if (req_ready === 1'b0 && resp_valid === 1'b0) zeros++;
        end
        chk("init_quiet_cycles", zeros, 127);
        @(posedge clk); #1;
        chk("ready_after_init", req_ready, 1);
        chk("no_resp_at_ready_rise", resp_valid, 0);

        step(1, 32'h0, 0, 0, 0, 0);
        chk("first_lookup_taken", resp_taken, 1);
        chk("first_lookup_pht", resp_pht_index, 0);

        step(0, 32'h0, 1, 0, 0, 0);
        step(0, 32'h0, 1, 0, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0);
        chk("two_nt_taken", resp_taken, 0);
        repeat (4) step(0, 32'h0, 1, 15, 0, 1);
        step(1, 32'h0, 0, 0, 0, 0);
        chk("saturated_taken", resp_taken, 1);
        step(0, 32'h0, 1, 15, 0, 0);
        step(1, 32'h0, 0, 0, 0, 0);
        chk("sat_minus_one_taken", resp_taken, 1);

        step(0, 32'h0, 1, 5, 127, 1);
        step(0, 32'h0, 1, 5, 127, 0);
        step(0, 32'h0, 1, 5, 127, 1);
        step(0, 32'h0, 1, 5, 127, 1);
        step(1, 32'h0000_01C8, 0, 0, 0, 0);
        chk("hist_bht_index", resp_bht_index, 5);
        chk("hist_pht_index", resp_pht_index, 7'h2B);

        step(1, 32'h0000_01C8, 1, 14, 7'h2B, 0);
`ifdef BP_BYPASS_EN
        chk("same_cycle_taken", resp_taken, 0);
`else
        chk("same_cycle_taken", resp_taken, 1);
`endif
        step(1, 32'h0000_01C8, 0, 0, 0, 0);
        chk("after_update_taken", resp_taken, 0);

        for (int i = 0; i < 400; i++) begin
            rv = 1'($urandom_range(0, 1));
            ue = 1'($urandom_range(0, 1));
            ut = 1'($urandom_range(0, 1));
            pc = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h0000_01FC) : $urandom;
            ub = ($urandom_range(0, 1) == 1) ? exp_bht : int'($urandom_range(0, 15));
            up = ($urandom_range(0, 1) == 1) ? exp_pht : int'($urandom_range(0, 127));
            step(rv, pc, ue, ub, up, ut);
        end

        step(1, 32'h0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_clears_resp_valid", resp_valid, 0);
        chk("rst_run_ready_low", req_ready, 0);
        reset     = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        upd_en    = 1'b1;
        upd_bht_index = 4'h0;
        upd_pht_index = 7'h0;
        upd_taken = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_init_ready_low", req_ready, 0);
        reset = 1'b0;
        model_init();
        zeros = 0;
        for (int k = 1; k <= 127; k++) begin
            @(posedge clk); #1;
            if (req_ready === 1'b0 && resp_valid === 1'b0) zeros++;
        end
        chk("reinit_quiet_cycles", zeros, 127);
        @(posedge clk); #1;
        chk("ready_after_reinit", req_ready, 1);
        step(1, 32'h0, 0, 0, 0, 0);
        chk("reinit_pc0_taken", resp_taken, 1);
        chk("reinit_pc0_pht", resp_pht_index, 0);
        step(1, 32'h0000_01C8, 0, 0, 0, 0);
        chk("reinit_bht5_pht", resp_pht_index, 7'h20);
        chk("reinit_bht5_taken", resp_taken, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_predictor_2lvl.md
# branch_predictor_2lvl

Parametrised two-level local branch predictor: per-branch history table (BHT) of shift registers feeding a pattern history table (PHT) of saturating counters. Sits in fetch: accepts a PC, returns a registered taken/not-taken prediction one cycle later, plus the BHT/PHT indices that travel down the pipeline to retire, where the resolved outcome is written back through the update port. Large tables are cleared by a sequential init walker, not a single-cycle reset.

## Interface
- BHT_ENTRIES, 16: BHT depth; power of two, ≥2; BHT_IDX = log2(BHT_ENTRIES).
- HIST_BITS, 4: history bits per BHT entry; ≥1.
- PC_PHT_BITS, 3: PC bits concatenated into the PHT index; ≥0.
- CTR_BITS, 2: PHT saturating-counter width; ≥1.
- Derived: PHT_IDX = PC_PHT_BITS + HIST_BITS; PHT_ENTRIES = 2^PHT_IDX.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  lookup request.
- req_ready  out  1  high only in RUN state.
- req_pc  in  32  fetch PC.
- resp_valid  out  1  prediction valid; one-cycle pulse per accepted request.
- resp_taken  out  1  predicted direction.
- resp_bht_index  out  BHT_IDX  BHT index used.
- resp_pht_index  out  PHT_IDX  PHT index used.
- upd_en  in  1  resolved-branch update strobe.
- upd_bht_index  in  BHT_IDX  BHT entry to shift.
- upd_pht_index  in  PHT_IDX  PHT counter to train.
- upd_taken  in  1  resolved direction.

## Operation
- States: INIT, RUN. Reset → INIT with init_ptr=0.
- INIT: each cycle writes BHT[init_ptr mod BHT_ENTRIES]=0 and PHT[init_ptr]=2^(CTR_BITS-1) (weakly taken); init_ptr++. After writing index max(PHT_ENTRIES,BHT_ENTRIES)-1 → RUN. req_ready=0; requests ignored; upd_en ignored (dropped).
- RUN: permanent until reset.
- BHT index: XOR-fold of req_pc[31:2] in BHT_IDX-bit chunks, LSB first; last partial chunk zero-extended.
- PHT index: {req_pc[PC_PHT_BITS+1:2], BHT[bht_idx]}; HIST_BITS only if PC_PHT_BITS=0.
- resp_taken = MSB of PHT[pht_idx].
- Update (RUN, upd_en=1): BHT[upd_bht_index] ← {old[HIST_BITS-2:0], upd_taken} (HIST_BITS=1: ← upd_taken). PHT[upd_pht_index] ← counter+1 if upd_taken, saturating at all-ones; counter−1 if not taken, saturating at 0.
- Lookup and update in the same cycle to the same entry: lookup reads pre-update values (read-before-write) unless the bypass macro is defined.
- Reset mid-INIT or mid-RUN: restarts INIT from index 0; any pending resp_valid is cleared.

## Timing
- Reset values: req_ready=0, resp_valid=0, resp_taken=0, resp_bht_index=0, resp_pht_index=0.
- Init duration: exactly max(PHT_ENTRIES,BHT_ENTRIES) cycles after reset deasserts; req_ready rises on the following cycle.
- Lookup latency: 1 cycle; request accepted at edge N (req_valid&&req_ready) → resp_* valid during cycle N+1. Back-to-back requests every cycle. No back-pressure on responses.
- resp_* fields hold last value when resp_valid=0.
- Update visible to lookups accepted at the next edge or later (same edge under bypass).

## Configuration
- BP_BYPASS_EN defined: same-cycle update forwarding. A lookup whose bht index equals upd_bht_index uses the post-shift history to form pht_idx; if the resulting pht_idx equals upd_pht_index, resp_taken is the MSB of the post-update counter.
- BP_BYPASS_EN undefined: pure read-before-write; no comparators.

## Test plan
- Default params, reset 1 cycle: req_ready=0 for exactly 128 cycles, then 1; resp_valid never asserts during INIT even with req_valid=1 held.
- After init, req_pc=0x0000_0000 → next cycle resp_valid=1, resp_taken=1, resp_bht_index=0, resp_pht_index=0.
- Two updates upd_pht_index=0, upd_taken=0, upd_bht_index=0 → lookup pc=0 gives resp_taken=0; four further taken updates → counter saturates at 3, taken=1; then one not-taken → counter 2, taken=1.
- Updates upd_bht_index=5 with taken sequence 1,0,1,1 → BHT[5]=4'b1011; lookup with PC hashing to 5 and pc[4:2]=3'b010 → resp_pht_index=7'b010_1011.
- Same-cycle update (not-taken, counter 2→1) and lookup to same entry → resp_taken=1 without BP_BYPASS_EN, 0 with it.
- Assert reset at init cycle 60 → INIT restarts; req_ready rises 128 cycles after the new reset release; entries written before the reset re-initialised.
